ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Selects one of two 16-bit pages (data_a / data_b) through a synchronised page-select switch and latches it once per frame, so each frame is coherent.
- Scans digits with an anti-ghosting blank gap, decodes hex to active-low segments, and optionally blanks leading zeros.
- Replaces the free-running ring counter plus combinational cathode mux at the display top level.

Parameters:
DIV, 200000, clk cycles per digit slot (must be >= 2)
GAP, 2000, all-anodes-off cycles at the start of each slot (1 <= GAP < DIV)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
data_a  input  16  page A, four hex nibbles; nibble 0 = [3:0] = rightmost digit
data_b  input  16  page B, same layout
sel  input  1  page select from board switch (asynchronous); 0 = A, 1 = B
blank_lz  input  1  1 = suppress leading zero digits (level, latched per frame)
an  output  4  anodes, active-low; an[0] = rightmost digit
seg  output  7  cathodes {a,b,c,d,e,f,g}, active-low
frame_start  output  1  one-cycle pulse marking the frame latch

Behaviour:
- Reset (reset=0), async and regardless of clk:
  - an=4'b1111, seg=7'b1111111, frame_start=0.
  - cnt=0, digit=0.
  - sel synchroniser flops=0; frame latches (data, blank_lz)=0.
- sel passes through a 2-flop synchroniser (sel_s). Latency 2 clk edges.
- Slot counter cnt runs 0..DIV-1 and wraps to 0.
  - On wrap, digit advances 0->1->2->3->0.
  - Frame = 4*DIV cycles.
- Phase per slot: GAP when cnt < GAP, ON when cnt >= GAP.
- Frame latch fires on every edge where cnt==0 && digit==0, including the first edge after reset release:
  - fdata <= sel_s ? data_b : data_a
  - flz <= blank_lz
  - frame_start registered high for the following cycle only.
- Page, data and blank_lz changes between latches have no effect until the next frame.
- Digit blanked when flz=1 && digit!=0 && fdata nibbles digit..3 are all zero.
  - Digit 0 is never blanked; value 0x0000 shows a single '0'.
- Outputs are registered and reflect the (cnt, digit) state present before each edge, i.e. one cycle of latency.
  - GAP phase, or blanked digit: an=1111, seg=1111111.
  - ON phase: an = ~(1<<digit), seg = hex decode of fdata nibble[digit].
- Hex decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Never more than one anode low. an transitions between two different digits always pass through 1111 for at least GAP cycles.
- Reset mid-slot: outputs blank immediately. After release, scan restarts at digit 0 GAP with a fresh latch.

Test Plan (DIV=8, GAP=2):
1. Hold reset=0 for 5 cycles with clk running, then pulse reset=0 asynchronously between edges during an ON phase -> an=1111, seg=1111111, frame_start=0 immediately, without waiting for a clock edge.
2. reset released, sel=0, data_a=16'h1234, blank_lz=0:
   - frame_start high once.
   - Each slot shows 2 cycles of 1111, then 6 cycles of the digit: an=1110 seg=1001100, an=1101 seg=0000110, an=1011 seg=0010010, an=0111 seg=1001111.
   - Pattern repeats every 32 cycles.
3. data_b=16'hABCD; sel 0->1 at cycle 10 of a frame:
   - Remaining digits of that frame still show 3, 2, 1 from data_a.
   - Next frame shows D(1000010), C(0110001), b(1100000), A(0001000).
4. blank_lz=1:
   - data_a=16'h0050 -> digit0 '0' (0000001), digit1 '5' (0100100), digit2 and digit3 slots an=1111 for all 8 cycles.
   - data_a=16'h0000 -> only digit0 shows '0'.
5. Change data_a from 16'h1234 to 16'h9999 during digit1 ON -> digits 1..3 of the current frame still show 3, 2, 1; next frame shows all '9' (0000100).
6. Reset asserted during digit2 ON, data_a changed to 16'h00FF, reset released -> first ON slot is an=1110 seg=0111000 ('F'). Bench checks no cycle with two anodes low over 1000 frames.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. A page (data_a or data_b) and the leading-zero mode
// are latched once per frame so every frame shows one coherent value. Each
// digit slot starts with an all-anodes-off gap to prevent ghosting.
module ssd_scan_ctrl #(
  parameter int unsigned DIV = 200000,  // clk cycles per digit slot (>= 2)
  parameter int unsigned GAP = 2000     // blank cycles at slot start (1 <= GAP < DIV)
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic        sel,          // asynchronous board switch; 0 = A, 1 = B
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {
    PH_GAP = 1'b0,
    PH_ON  = 1'b1
  } phase_t;

  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic          sel_meta;
  logic          sel_s;
  logic [15:0]   fdata;
  logic          flz;

  logic          frame_edge;
  phase_t        phase;
  logic [3:0]    nibble;
  logic          upper_zero;
  logic          blank_digit;

  // Hex nibble to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b0000001;
      4'h1:    pattern = 7'b1001111;
      4'h2:    pattern = 7'b0010010;
      4'h3:    pattern = 7'b0000110;
      4'h4:    pattern = 7'b1001100;
      4'h5:    pattern = 7'b0100100;
      4'h6:    pattern = 7'b0100000;
      4'h7:    pattern = 7'b0001111;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0000100;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b1100000;
      4'hC:    pattern = 7'b0110001;
      4'hD:    pattern = 7'b1000010;
      4'hE:    pattern = 7'b0110000;
      default: pattern = 7'b0111000;
    endcase
    return pattern;
  endfunction

  // Two-flop synchroniser for the asynchronous page-select switch.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, which is what makes this a two-stage chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_meta <= 1'b0;
      sel_s    <= 1'b0;
    end else begin
      sel_meta <= sel;
      sel_s    <= sel_meta;
    end
  end

  // Slot counter and digit index: cnt wraps every DIV cycles, digit steps on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      digit <= 2'd0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt   <= '0;
      digit <= digit + 2'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign frame_edge = (cnt == '0) && (digit == 2'd0);

  // Per-frame latch of page data and blanking mode, with a one-cycle marker pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fdata       <= 16'h0000;
      flz         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (frame_edge) begin
        fdata <= sel_s ? data_b : data_a;
        flz   <= blank_lz;
      end
    end
  end

  // Slot phase, selected nibble and leading-zero blanking for the current digit.
  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    phase      = (cnt < CW'(GAP)) ? PH_GAP : PH_ON;
    nibble     = fdata[3:0];
    upper_zero = 1'b0;
    case (digit)
      2'd0: begin
        nibble     = fdata[3:0];
        upper_zero = 1'b0;  // rightmost digit always shows, so 0x0000 reads '0'
      end
      2'd1: begin
        nibble     = fdata[7:4];
        upper_zero = (fdata[15:4] == 12'h000);
      end
      2'd2: begin
        nibble     = fdata[11:8];
        upper_zero = (fdata[15:8] == 8'h00);
      end
      default: begin
        nibble     = fdata[15:12];
        upper_zero = (fdata[15:12] == 4'h0);
      end
    endcase
    blank_digit = flz & upper_zero;
  end

  // Registered anode/cathode drive: dark during the gap or for a suppressed digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else if (phase == PH_GAP || blank_digit) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << digit);
      seg <= hex_to_seg(nibble);
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with DIV=8, GAP=2. The stimulus process
// runs a frame-level reference model at every clock edge and queues the
// expected outputs; a monitor on the falling edge pops and compares.
module tb_ssd_scan_ctrl;

  localparam int DIV = 8;
  localparam int GAP = 2;
  localparam int FR  = 4 * DIV;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_a = 16'h0000;
  logic [15:0] data_b = 16'h0000;
  logic        sel = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  ssd_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_a      (data_a),
    .data_b      (data_b),
    .sel         (sel),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: edges since reset release, frame snapshot, sel history.
  int          m_e    = 0;
  logic [15:0] m_snap = 16'h0000;
  logic        m_flz  = 1'b0;
  logic        m_s1   = 1'b0;
  logic        m_s2   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  task automatic m_reset();
    m_e    = 0;
    m_snap = 16'h0000;
    m_flz  = 1'b0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
  endtask

  // One clock edge: capture inputs, wait for the edge, queue the expectation.
  task automatic step();
    logic        r, s, bl;
    logic [15:0] da, db, sh;
    int          slot, dig;
    bit          dark;
    exp_t        x;
    r = reset; s = sel; bl = blank_lz; da = data_a; db = data_b;
    @(posedge clk);
    if (!r) begin
      x.an = 4'b1111; x.seg = 7'b1111111; x.fs = 1'b0;
      exp_q.push_back(x);
      m_reset();
    end else begin
      slot = m_e % DIV;
      dig  = (m_e / DIV) % 4;
      sh   = m_snap >> (4 * dig);
      dark = (slot < GAP) || (m_flz && dig != 0 && sh == 16'h0000);
      if (dark) begin
        x.an = 4'b1111; x.seg = 7'b1111111;
      end else begin
        x.an  = ~(4'b0001 << dig);
        x.seg = HEX[sh[3:0]];
      end
      x.fs = (slot == 0 && dig == 0);
      exp_q.push_back(x);
      if (x.fs) begin
        m_snap = m_s2 ? db : da;
        m_flz  = bl;
      end
      m_s2 = m_s1;
      m_s1 = s;
      m_e++;
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the next edge is at position k within the frame.
  task automatic run_to(input int k);
    for (int i = 0; i < 2 * FR; i++) begin
      if (m_e % FR == k) return;
      step();
    end
    check("run_to_bound", 16'(m_e % FR), 16'(k));
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    check("rst_async_an", {12'h000, an}, 16'h000F);
    check("rst_async_seg", {9'h000, seg}, 16'h007F);
    check("rst_async_fs", {15'h0000, frame_start}, 16'h0000);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] v;
    v = 16'($urandom);
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 0) v[4*i +: 4] = 4'h0;
    return v;
  endfunction

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("an", {12'h000, an}, {12'h000, x.an});
      check("seg", {9'h000, seg}, {9'h000, x.seg});
      check("frame_start", {15'h0000, frame_start}, {15'h0000, x.fs});
      check("one_anode", 16'($countones(~an) <= 1), 16'h0001);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with the clock running, then an asynchronous pulse mid-ON.
    run(5);
    release_reset();
    data_a = 16'h1234;
    run_to(4);
    assert_reset();
    run(2);
    release_reset();

    // Steady scan of 0x1234 over two frames.
    run(2 * FR);

    // Page switch mid-frame takes effect on the following frame only.
    data_b = 16'hABCD;
    run_to(10);
    sel = 1'b1;
    run(2 * FR + 4);

    // Leading-zero suppression.
    sel = 1'b0;
    blank_lz = 1'b1;
    data_a = 16'h0050;
    run(2 * FR);
    data_a = 16'h0000;
    run(2 * FR);

    // Data change during digit1 ON stays hidden until the next frame.
    blank_lz = 1'b0;
    data_a = 16'h1234;
    run_to(0);
    run(FR);
    run_to(DIV + 3);
    data_a = 16'h9999;
    run(2 * FR);

    // Reset during digit2 ON with new data, then a fresh frame showing 'F'.
    data_a = 16'h1234;
    run_to(2 * DIV + 4);
    assert_reset();
    data_a = 16'h00FF;
    run(3);
    release_reset();
    run(2 * FR);

    // Randomised long run: 1000 frames with input churn and rare resets.
    for (int c = 0; c < 1000 * FR; c++) begin
      if ($urandom_range(0, 15) == 0) data_a = rnd_data();
      if ($urandom_range(0, 15) == 0) data_b = rnd_data();
      if ($urandom_range(0, 31) == 0) sel = ~sel;
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 4999) == 0) begin
        assert_reset();
        run($urandom_range(1, 4));
        release_reset();
      end
      step();
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
